led_sequencer: RTL and testbench

Pattern controller for the blinky LED bank: divides the board clock into a programmable step tick and drives NUM_LEDS outputs through one of four patterns. A requester reconfigures it through a valid/ready handshake. New settings are applied only on a step boundary, so the LEDs never glitch mid-step. It sits between the clock input and the LED output buffers, replacing the free-running blinky counter.

---
 rtl/led_seq_pkg.sv | 57 +++++
 rtl/led_prescaler.sv | 41 ++++
 rtl/led_sequencer.sv | 130 +++++++++++++
 tb/tb_led_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared modes, FSM states and pattern step function for the LED sequencer
package led_seq_pkg;

    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_STATIC = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        ST_RUN,
        ST_PENDING
    } state_e;

    // One step of the free-running patterns on an LED bank of width n (n <= 32).
    // Returns {dir, led}; STATIC leaves led untouched, the caller substitutes its pattern.
    function automatic logic [32:0] next_pattern(input logic [1:0] mode,
                                                 input logic [31:0] led,
                                                 input logic dir,
                                                 input int unsigned n);
        logic [31:0] mask;
        logic [31:0] msb;
        logic [31:0] cur;
        logic [31:0] nled;
        logic        ndir;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        msb  = mask & ~(mask >> 1);
        cur  = led & mask;
        nled = cur;
        ndir = dir;
        case (mode)
            MODE_COUNT: nled = (cur + 32'd1) & mask;
            MODE_BOUNCE: begin
                if (!$onehot(cur)) begin
                    nled = 32'd1;
                    ndir = DIR_LEFT;
                end else if (dir == DIR_LEFT && (cur & msb) != 32'd0) begin
                    ndir = DIR_RIGHT;
                    nled = cur >> 1;
                end else if (dir == DIR_RIGHT && cur[0]) begin
                    ndir = DIR_LEFT;
                    nled = (cur << 1) & mask;
                end else if (dir == DIR_LEFT) begin
                    nled = (cur << 1) & mask;
                end else begin
                    nled = cur >> 1;
                end
            end
            MODE_BLINK: nled = ~cur & mask;
            default:    nled = cur;
        endcase
        return {ndir, nled};
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - step-tick prescaler; a divisor of zero behaves as one
module led_prescaler
    import led_seq_pkg::*;
#(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clki,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 step
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [DIV_WIDTH-1:0] d_eff;

    assign d_eff = (div == '0) ? DIV_WIDTH'(1) : div;
    assign step  = enable && (cnt_q == d_eff - DIV_WIDTH'(1));

    // Next count: wrap on the step edge or on a config apply, hold while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear || step) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer with step-aligned reconfiguration
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS    = 4,
    parameter int DIV_WIDTH   = 24,
    parameter int DEFAULT_DIV = 900000
) (
    input  logic                 clki,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_mode,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [NUM_LEDS-1:0]  cfg_pattern,
    output logic [NUM_LEDS-1:0]  led,
    output logic                 tick
);

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [NUM_LEDS-1:0]  pat_q, pat_d;
    logic [1:0]           pmode_q, pmode_d;
    logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
    logic [NUM_LEDS-1:0]  ppat_q, ppat_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 dir_q, dir_d;
    logic                 tick_q, tick_d;
    logic                 ready_q, ready_d;

    logic                 step;
    logic                 apply;
    logic                 transfer;
    logic [32:0]          pattern_nxt;
    logic                 unused_pattern_bits;
    logic [NUM_LEDS-1:0]  init_led;

    // A pending config lands on the next step edge, or immediately while frozen
    assign apply    = (state_q == ST_PENDING) && (step || !enable);
    assign transfer = cfg_valid && ready_q;

    assign pattern_nxt         = next_pattern(mode_q, 32'(led_q), dir_q, NUM_LEDS);
    assign unused_pattern_bits = ^pattern_nxt;

    assign init_led = (pmode_q == MODE_BOUNCE) ? NUM_LEDS'(1) :
                      (pmode_q == MODE_STATIC) ? ppat_q : '0;

    led_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clki   (clki),
        .rst    (rst),
        .enable (enable),
        .clear  (apply),
        .div    (div_q),
        .step   (step)
    );

    // Next state: apply pending config, else normal step, plus handshake capture
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        pat_d   = pat_q;
        pmode_d = pmode_q;
        pdiv_d  = pdiv_q;
        ppat_d  = ppat_q;
        led_d   = led_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        ready_d = ready_q;
        if (apply) begin
            mode_d  = pmode_q;
            div_d   = pdiv_q;
            pat_d   = ppat_q;
            led_d   = init_led;
            dir_d   = DIR_LEFT;
            tick_d  = step;
            ready_d = 1'b1;
            state_d = ST_RUN;
        end else if (step) begin
            led_d  = (mode_q == MODE_STATIC) ? pat_q : pattern_nxt[NUM_LEDS-1:0];
            dir_d  = pattern_nxt[32];
            tick_d = 1'b1;
        end
        if (transfer) begin
            pmode_d = cfg_mode;
            pdiv_d  = cfg_div;
            ppat_d  = cfg_pattern;
            ready_d = 1'b0;
            state_d = ST_PENDING;
        end
    end

    // Sequencer registers
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            mode_q  <= MODE_COUNT;
            div_q   <= DIV_WIDTH'(DEFAULT_DIV);
            pat_q   <= '0;
            pmode_q <= MODE_COUNT;
            pdiv_q  <= '0;
            ppat_q  <= '0;
            led_q   <= '0;
            dir_q   <= DIR_LEFT;
            tick_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            pat_q   <= pat_d;
            pmode_q <= pmode_d;
            pdiv_q  <= pdiv_d;
            ppat_q  <= ppat_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
        end
    end

    assign led       = led_q;
    assign tick      = tick_q;
    assign cfg_ready = ready_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed self-checking bench for led_sequencer
module tb_led_sequencer;

    logic        clki = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_mode = 2'd0;
    logic [23:0] cfg_div = 24'd0;
    logic [3:0]  cfg_pattern = 4'd0;
    logic [3:0]  led;
    logic        tick;

    int n_checks = 0;
    int n_pass = 0;
    int cyc;

    led_sequencer #(
        .NUM_LEDS    (4),
        .DIV_WIDTH   (24),
        .DEFAULT_DIV (4)
    ) dut (
        .clki        (clki),
        .rst         (rst),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_div     (cfg_div),
        .cfg_pattern (cfg_pattern),
        .led         (led),
        .tick        (tick)
    );

    always #5 clki = ~clki;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clki);
        #1;
    endtask

    // Clock until tick is seen (bounded); returns number of edges taken
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            clk1();
            n++;
        end while (!tick && n < 20);
    endtask

    task automatic offer(input logic [1:0] m, input logic [23:0] d, input logic [3:0] p);
        cfg_valid   = 1'b1;
        cfg_mode    = m;
        cfg_div     = d;
        cfg_pattern = p;
    endtask

    initial begin
        logic [3:0] bounce_exp [7];
        bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        // Reset state
        repeat (3) clk1();
        check("rst_led", 32'(led), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;

        // 1: COUNT with divisor 4, full wrap
        for (int i = 0; i < 16; i++) begin
            wait_tick(cyc);
            check("t1_period", 32'(cyc), 32'd4);
            check("t1_led", 32'(led), 32'((i + 1) % 16));
            check("t1_ready", 32'(cfg_ready), 32'd1);
        end

        // 2: BOUNCE div 2
        offer(2'd1, 24'd2, 4'd0);
        clk1();
        cfg_valid = 1'b0;
        check("t2_ready_low", 32'(cfg_ready), 32'd0);
        wait_tick(cyc);
        check("t2_apply_wait", 32'(cyc), 32'd3);
        check("t2_apply_led", 32'(led), 32'b0001);
        check("t2_ready_back", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            wait_tick(cyc);
            check("t2_period", 32'(cyc), 32'd2);
            check("t2_led", 32'(led), 32'(bounce_exp[i]));
        end

        // 3: back to COUNT div 4, then transfer coinciding with a step edge
        offer(2'd0, 24'd4, 4'd0);
        clk1();
        cfg_valid = 1'b0;
        wait_tick(cyc);
        check("t3_cnt_apply", 32'(cyc), 32'd1);
        check("t3_cnt_led", 32'(led), 32'd0);
        repeat (3) clk1();
        check("t3_pre_tick", 32'(tick), 32'd0);
        offer(2'd2, 24'd3, 4'd0);
        clk1();
        cfg_valid = 1'b0;
        check("t3_edge_tick", 32'(tick), 32'd1);
        check("t3_edge_led", 32'(led), 32'd1);
        check("t3_edge_ready", 32'(cfg_ready), 32'd0);
        wait_tick(cyc);
        check("t3_old_div", 32'(cyc), 32'd4);
        check("t3_blink_led", 32'(led), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wait_tick(cyc);
            check("t3_period", 32'(cyc), 32'd3);
            check("t3_toggle", 32'(led), (i % 2 == 0) ? 32'hF : 32'h0);
        end

        // 4: frozen apply of STATIC 1010
        clk1();
        enable = 1'b0;
        offer(2'd3, 24'd4, 4'b1010);
        clk1();
        cfg_valid = 1'b0;
        check("t4_xfer_ready", 32'(cfg_ready), 32'd0);
        check("t4_xfer_led", 32'(led), 32'hF);
        clk1();
        check("t4_apply_led", 32'(led), 32'b1010);
        check("t4_apply_tick", 32'(tick), 32'd0);
        check("t4_apply_ready", 32'(cfg_ready), 32'd1);
        repeat (5) clk1();
        check("t4_frozen_tick", 32'(tick), 32'd0);
        check("t4_frozen_led", 32'(led), 32'b1010);
        enable = 1'b1;
        wait_tick(cyc);
        check("t4_reen_period", 32'(cyc), 32'd4);
        check("t4_reen_led", 32'(led), 32'b1010);

        // 5: divisor 0 behaves as 1
        offer(2'd0, 24'd0, 4'd0);
        clk1();
        cfg_valid = 1'b0;
        wait_tick(cyc);
        check("t5_apply_wait", 32'(cyc), 32'd3);
        check("t5_apply_led", 32'(led), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            wait_tick(cyc);
            check("t5_period", 32'(cyc), 32'd1);
            check("t5_led", 32'(led), 32'(i));
        end

        // 6: switch to div 4 (transfer on a step edge at d=1), then reset while pending
        offer(2'd0, 24'd4, 4'd0);
        clk1();
        cfg_valid = 1'b0;
        check("t6_edge_led", 32'(led), 32'd5);
        check("t6_edge_ready", 32'(cfg_ready), 32'd0);
        clk1();
        check("t6_apply_led", 32'(led), 32'd0);
        check("t6_apply_tick", 32'(tick), 32'd1);
        wait_tick(cyc);
        check("t6_period", 32'(cyc), 32'd4);
        check("t6_led", 32'(led), 32'd1);
        offer(2'd2, 24'd2, 4'd0);
        clk1();
        cfg_valid = 1'b0;
        clk1();
        check("t6_pending", 32'(cfg_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_led", 32'(led), 32'd0);
        check("t6_rst_tick", 32'(tick), 32'd0);
        check("t6_rst_ready", 32'(cfg_ready), 32'd1);
        clk1();
        rst = 1'b0;
        wait_tick(cyc);
        check("t6_post_period", 32'(cyc), 32'd4);
        check("t6_post_led", 32'(led), 32'd1);
        check("t6_post_ready", 32'(cfg_ready), 32'd1);
        wait_tick(cyc);
        check("t6_post_led2", 32'(led), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
